// File: rtl/alu_multicycle_pkg.sv
// Shared widths, op/branch codes and FSM encodings for the multi-cycle ALU.
package alu_multicycle_pkg;

    localparam int unsigned kALU_DATA_WIDTH       = 32;
    localparam int unsigned kALU_SHAMT_WIDTH      = 5;
    localparam int unsigned kALU_OP_SEL_WIDTH     = 4;
    localparam int unsigned kALU_BRANCH_SEL_WIDTH = 3;
    localparam int unsigned kALU_MC_STATE_WIDTH   = 2;
    localparam int unsigned kALU_SHIFT_STEP_WIDE  = 4;

    localparam logic [kALU_MC_STATE_WIDTH-1:0] kALU_MC_STATE_IDLE  = 2'd0;
    localparam logic [kALU_MC_STATE_WIDTH-1:0] kALU_MC_STATE_SHIFT = 2'd1;
    localparam logic [kALU_MC_STATE_WIDTH-1:0] kALU_MC_STATE_DONE  = 2'd2;

    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_ADD     = 4'd0;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_SUB     = 4'd1;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_SLL     = 4'd2;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_SLT     = 4'd3;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_XOR     = 4'd4;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_SRL     = 4'd5;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_SRA     = 4'd6;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_OR      = 4'd7;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_AND     = 4'd8;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_BRANCH  = 4'd9;
    localparam logic [kALU_OP_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_ILLEGAL = 4'd15;

    // Branch selects follow the RV32I funct3 encoding.
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_BEQ  = 3'd0;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_BNE  = 3'd1;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_BLT  = 3'd4;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_BGE  = 3'd5;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_BLTU = 3'd6;
    localparam logic [kALU_BRANCH_SEL_WIDTH-1:0] kSAIL_ALUCTL_6to0_BGEU = 3'd7;

    typedef enum logic [kALU_MC_STATE_WIDTH-1:0] {
        ST_IDLE  = kALU_MC_STATE_IDLE,
        ST_SHIFT = kALU_MC_STATE_SHIFT,
        ST_DONE  = kALU_MC_STATE_DONE
    } alu_mc_state_e;

    typedef enum logic [1:0] {
        SH_LEFT   = 2'd0,
        SH_LRIGHT = 2'd1,
        SH_ARIGHT = 2'd2
    } shift_dir_e;

endpackage

// File: rtl/alu_shift_step.sv
// One step of the iterative shifter: shifts by 1, or by the wide step when step4_i is set.
module alu_shift_step
    import alu_multicycle_pkg::*;
(
    input  logic [kALU_DATA_WIDTH-1:0] data_i,
    input  shift_dir_e                 dir_i,
    input  logic                       step4_i,
    output logic [kALU_DATA_WIDTH-1:0] data_o
);

    localparam int unsigned kW = kALU_DATA_WIDTH;
    localparam int unsigned kS = kALU_SHIFT_STEP_WIDE;

    always_comb begin
        data_o = data_i;
        case (dir_i)
            SH_LEFT:   data_o = step4_i ? {data_i[kW-kS-1:0], {kS{1'b0}}}
                                        : {data_i[kW-2:0], 1'b0};
            SH_LRIGHT: data_o = step4_i ? {{kS{1'b0}}, data_i[kW-1:kS]}
                                        : {1'b0, data_i[kW-1:1]};
            SH_ARIGHT: data_o = step4_i ? {{kS{data_i[kW-1]}}, data_i[kW-1:kS]}
                                        : {data_i[kW-1], data_i[kW-1:1]};
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith/compare/branch, iterative shifts.
// Build option: ALU_MC_SHIFT4_EN enables 4-bit shift steps while the count is >= 4.
module alu_multicycle
    import alu_multicycle_pkg::*;
(
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             start_i,
    input  logic [kALU_OP_SEL_WIDTH-1:0]     alu_op_sel_i,
    input  logic [kALU_BRANCH_SEL_WIDTH-1:0] alu_branch_sel_i,
    input  logic                             unsigned_i,
    input  logic [kALU_DATA_WIDTH-1:0]       a_i,
    input  logic [kALU_DATA_WIDTH-1:0]       b_i,
    output logic                             ready_o,
    output logic                             done_o,
    output logic [kALU_DATA_WIDTH-1:0]       result_o,
    output logic                             branch_taken_o,
    output logic                             illegal_o
);

    alu_mc_state_e                state_q, state_d;
    logic [kALU_DATA_WIDTH-1:0]   work_q, work_d;
    logic [kALU_SHAMT_WIDTH-1:0]  count_q, count_d;
    shift_dir_e                   dir_q, dir_d;
    logic [kALU_DATA_WIDTH-1:0]   result_q, result_d;
    logic                         branch_q, branch_d;
    logic                         illegal_q, illegal_d;
    logic                         done_q, done_d;

    logic [kALU_DATA_WIDTH-1:0]   op_result_c;
    logic                         op_branch_c;
    logic                         op_illegal_c;
    logic                         is_shift_c;
    shift_dir_e                   op_dir_c;
    logic                         lt_signed_c, lt_unsigned_c;
    logic [kALU_SHAMT_WIDTH-1:0]  shamt_c;
    logic                         accept_c;
    logic                         step4_c;
    logic [kALU_SHAMT_WIDTH-1:0]  step_amt_c;
    logic [kALU_DATA_WIDTH-1:0]   shifted_c;

    assign shamt_c       = b_i[kALU_SHAMT_WIDTH-1:0];
    assign lt_signed_c   = $signed(a_i) < $signed(b_i);
    assign lt_unsigned_c = a_i < b_i;
    assign ready_o       = reset_n_i && (state_q == ST_IDLE || state_q == ST_DONE);
    assign accept_c      = start_i && ready_o;

    // Single-cycle result; shift ops here only cover the shamt=0 case.
    always_comb begin
        op_result_c  = '0;
        op_branch_c  = 1'b0;
        op_illegal_c = 1'b0;
        is_shift_c   = 1'b0;
        op_dir_c     = SH_LEFT;
        case (alu_op_sel_i)
            kSAIL_ALUCTL_6to0_ADD: op_result_c = a_i + b_i;
            kSAIL_ALUCTL_6to0_SUB: op_result_c = a_i - b_i;
            kSAIL_ALUCTL_6to0_AND: op_result_c = a_i & b_i;
            kSAIL_ALUCTL_6to0_OR:  op_result_c = a_i | b_i;
            kSAIL_ALUCTL_6to0_XOR: op_result_c = a_i ^ b_i;
            kSAIL_ALUCTL_6to0_SLT:
                op_result_c = kALU_DATA_WIDTH'(unsigned_i ? lt_unsigned_c : lt_signed_c);
            kSAIL_ALUCTL_6to0_SLL: begin
                op_result_c = a_i;
                is_shift_c  = 1'b1;
                op_dir_c    = SH_LEFT;
            end
            kSAIL_ALUCTL_6to0_SRL: begin
                op_result_c = a_i;
                is_shift_c  = 1'b1;
                op_dir_c    = SH_LRIGHT;
            end
            kSAIL_ALUCTL_6to0_SRA: begin
                op_result_c = a_i;
                is_shift_c  = 1'b1;
                op_dir_c    = SH_ARIGHT;
            end
            kSAIL_ALUCTL_6to0_BRANCH: begin
                case (alu_branch_sel_i)
                    kSAIL_ALUCTL_6to0_BEQ:  op_branch_c = (a_i == b_i);
                    kSAIL_ALUCTL_6to0_BNE:  op_branch_c = (a_i != b_i);
                    kSAIL_ALUCTL_6to0_BLT:  op_branch_c = lt_signed_c;
                    kSAIL_ALUCTL_6to0_BGE:  op_branch_c = !lt_signed_c;
                    kSAIL_ALUCTL_6to0_BLTU: op_branch_c = lt_unsigned_c;
                    kSAIL_ALUCTL_6to0_BGEU: op_branch_c = !lt_unsigned_c;
                    default:                op_branch_c = 1'b0;
                endcase
            end
            default: op_illegal_c = 1'b1;
        endcase
    end

`ifdef ALU_MC_SHIFT4_EN
    assign step4_c = (count_q >= kALU_SHAMT_WIDTH'(kALU_SHIFT_STEP_WIDE));
`else
    assign step4_c = 1'b0;
`endif
    assign step_amt_c = step4_c ? kALU_SHAMT_WIDTH'(kALU_SHIFT_STEP_WIDE)
                                : kALU_SHAMT_WIDTH'(1);

    alu_shift_step u_shift_step (
        .data_i  (work_q),
        .dir_i   (dir_q),
        .step4_i (step4_c),
        .data_o  (shifted_c)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            count_q   <= '0;
            dir_q     <= SH_LEFT;
            result_q  <= '0;
            branch_q  <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            count_q   <= count_d;
            dir_q     <= dir_d;
            result_q  <= result_d;
            branch_q  <= branch_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
        end
    end

    // Next state; results are only written on the edge that enters DONE.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        count_d   = count_q;
        dir_d     = dir_q;
        result_d  = result_q;
        branch_d  = branch_q;
        illegal_d = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (accept_c) begin
                    if (is_shift_c && shamt_c != '0) begin
                        state_d = ST_SHIFT;
                        work_d  = a_i;
                        count_d = shamt_c;
                        dir_d   = op_dir_c;
                    end else begin
                        state_d   = ST_DONE;
                        result_d  = op_result_c;
                        branch_d  = op_branch_c;
                        illegal_d = op_illegal_c;
                        done_d    = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                work_d  = shifted_c;
                count_d = count_q - step_amt_c;
                if (count_q == step_amt_c) begin
                    state_d  = ST_DONE;
                    result_d = shifted_c;
                    branch_d = 1'b0;
                    done_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign done_o         = done_q;
    assign result_o       = result_q;
    assign branch_taken_o = branch_q;
    assign illegal_o      = illegal_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle; inputs driven and outputs sampled on negedge.
module tb_alu_multicycle;
    import alu_multicycle_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  alu_op_sel_i = '0;
    logic [2:0]  alu_branch_sel_i = '0;
    logic        unsigned_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        ready_o, done_o, branch_taken_o, illegal_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    alu_multicycle dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .start_i(start_i),
        .alu_op_sel_i(alu_op_sel_i), .alu_branch_sel_i(alu_branch_sel_i),
        .unsigned_i(unsigned_i), .a_i(a_i), .b_i(b_i),
        .ready_o(ready_o), .done_o(done_o), .result_o(result_o),
        .branch_taken_o(branch_taken_o), .illegal_o(illegal_o)
    );

    always #5 clk_i = ~clk_i;

`ifdef ALU_MC_SHIFT4_EN
    localparam int kLAT_SRA4  = 2;
    localparam int kLAT_SLL5  = 3;
    localparam int kLAT_SRL31 = 11;
`else
    localparam int kLAT_SRA4  = 5;
    localparam int kLAT_SLL5  = 6;
    localparam int kLAT_SRL31 = 32;
`endif

    // Present a request for one cycle; returns at the negedge after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [2:0] br, input logic uns,
                         input logic [31:0] a, input logic [31:0] b);
        alu_op_sel_i = op; alu_branch_sel_i = br; unsigned_i = uns; a_i = a; b_i = b;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    // Cycles until done_o, counting the negedge right after accept as 1; 999 on timeout.
    task automatic wait_done(input int start_n, output int n);
        n = start_n;
        while (!done_o && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        if (!done_o) n = 999;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready_low got %b want 0", ready_o); end
        checks++;
        if ({done_o, branch_taken_o, illegal_o, result_o} !== 35'd0) begin
            errors++; $display("FAIL reset_outputs got done=%b br=%b ill=%b res=%h want 0", done_o, branch_taken_o, illegal_o, result_o);
        end
        reset_n_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready_after got %b want 1", ready_o); end
    endtask

    task automatic test_add_sub();
        issue(kSAIL_ALUCTL_6to0_ADD, 3'd0, 1'b0, 32'h7FFF_FFFF, 32'h1);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h8000_0000 || illegal_o !== 1'b0 || branch_taken_o !== 1'b0) begin
            errors++; $display("FAIL add_ovf got done=%b res=%h ill=%b br=%b want 1 80000000 0 0", done_o, result_o, illegal_o, branch_taken_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || result_o !== 32'h8000_0000) begin
            errors++; $display("FAIL add_hold got done=%b res=%h want 0 80000000", done_o, result_o);
        end
        issue(kSAIL_ALUCTL_6to0_SUB, 3'd0, 1'b0, 32'h0, 32'h1);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL sub_wrap got done=%b res=%h want 1 ffffffff", done_o, result_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_logic();
        logic [3:0]  ops [3]  = '{kSAIL_ALUCTL_6to0_AND, kSAIL_ALUCTL_6to0_OR, kSAIL_ALUCTL_6to0_XOR};
        logic [31:0] exps [3] = '{32'h00F0_000F, 32'hFFF0_0FFF, 32'hFF00_0FF0};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], 3'd0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F);
            checks++;
            if (done_o !== 1'b1 || result_o !== exps[i]) begin
                errors++; $display("FAIL logic_%0d got done=%b res=%h want 1 %h", i, done_o, result_o, exps[i]);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_slt();
        issue(kSAIL_ALUCTL_6to0_SLT, 3'd0, 1'b0, 32'hFFFF_FFFF, 32'h1);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h1) begin
            errors++; $display("FAIL slt_signed got done=%b res=%h want 1 00000001", done_o, result_o);
        end
        issue(kSAIL_ALUCTL_6to0_SLT, 3'd0, 1'b1, 32'hFFFF_FFFF, 32'h1);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h0) begin
            errors++; $display("FAIL slt_unsigned got done=%b res=%h want 1 00000000", done_o, result_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_branch();
        logic [2:0]  sels [7] = '{kSAIL_ALUCTL_6to0_BLTU, kSAIL_ALUCTL_6to0_BGE, kSAIL_ALUCTL_6to0_BEQ,
                                  kSAIL_ALUCTL_6to0_BNE, kSAIL_ALUCTL_6to0_BLT, kSAIL_ALUCTL_6to0_BGEU, 3'd2};
        logic [31:0] as [7]   = '{32'h1, 32'h1, 32'h5, 32'h5, 32'h1, 32'h1, 32'h5};
        logic [31:0] bs [7]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5, 32'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h5};
        logic        tk [7]   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        issue(kSAIL_ALUCTL_6to0_ADD, 3'd0, 1'b0, 32'h10, 32'h20);
        for (int i = 0; i < 7; i++) begin
            issue(kSAIL_ALUCTL_6to0_BRANCH, sels[i], 1'b0, as[i], bs[i]);
            checks++;
            if (done_o !== 1'b1 || branch_taken_o !== tk[i] || result_o !== 32'h0 || illegal_o !== 1'b0) begin
                errors++; $display("FAIL branch_%0d got done=%b br=%b res=%h ill=%b want 1 %b 0 0", i, done_o, branch_taken_o, result_o, illegal_o, tk[i]);
            end
        end
        issue(kSAIL_ALUCTL_6to0_BRANCH, kSAIL_ALUCTL_6to0_BEQ, 1'b0, 32'h7, 32'h7);
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || branch_taken_o !== 1'b1) begin
            errors++; $display("FAIL branch_hold got done=%b br=%b want 0 1", done_o, branch_taken_o);
        end
    endtask

    task automatic test_shift();
        int n;
        issue(kSAIL_ALUCTL_6to0_SRA, 3'd0, 1'b0, 32'h8000_0000, 32'h4);
        checks++;
        if (ready_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL sra_busy got ready=%b done=%b want 0 0", ready_o, done_o);
        end
        issue(kSAIL_ALUCTL_6to0_ADD, 3'd0, 1'b0, 32'h1, 32'h1);
        wait_done(2, n);
        checks++;
        if (n !== kLAT_SRA4 || result_o !== 32'hF800_0000 || branch_taken_o !== 1'b0) begin
            errors++; $display("FAIL sra4 got lat=%0d res=%h br=%b want %0d f8000000 0", n, result_o, branch_taken_o, kLAT_SRA4);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0 || result_o !== 32'hF800_0000) begin
            errors++; $display("FAIL sra_ignored_start got done=%b res=%h want 0 f8000000", done_o, result_o);
        end
        issue(kSAIL_ALUCTL_6to0_SLL, 3'd0, 1'b0, 32'h0000_0003, 32'hFFFF_FFE0);
        checks++;
        if (done_o !== 1'b1 || result_o !== 32'h0000_0003) begin
            errors++; $display("FAIL sll0 got done=%b res=%h want 1 00000003", done_o, result_o);
        end
        issue(kSAIL_ALUCTL_6to0_SLL, 3'd0, 1'b0, 32'h0000_0003, 32'h5);
        wait_done(1, n);
        checks++;
        if (n !== kLAT_SLL5 || result_o !== 32'h0000_0060) begin
            errors++; $display("FAIL sll5 got lat=%0d res=%h want %0d 00000060", n, result_o, kLAT_SLL5);
        end
        @(negedge clk_i);
        issue(kSAIL_ALUCTL_6to0_SRL, 3'd0, 1'b0, 32'h8000_0000, 32'h1F);
        wait_done(1, n);
        checks++;
        if (n !== kLAT_SRL31 || result_o !== 32'h0000_0001) begin
            errors++; $display("FAIL srl31 got lat=%0d res=%h want %0d 00000001", n, result_o, kLAT_SRL31);
        end
        @(negedge clk_i);
    endtask

    task automatic test_back_to_back();
        alu_op_sel_i = kSAIL_ALUCTL_6to0_ILLEGAL; a_i = 32'h9; b_i = 32'h9;
        start_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b1 || illegal_o !== 1'b1 || result_o !== 32'h0 || branch_taken_o !== 1'b0 || ready_o !== 1'b1) begin
            errors++; $display("FAIL illegal got done=%b ill=%b res=%h br=%b rdy=%b want 1 1 0 0 1", done_o, illegal_o, result_o, branch_taken_o, ready_o);
        end
        alu_op_sel_i = kSAIL_ALUCTL_6to0_ADD; a_i = 32'h2; b_i = 32'h3;
        @(negedge clk_i);
        start_i = 1'b0;
        checks++;
        if (done_o !== 1'b1 || illegal_o !== 1'b0 || result_o !== 32'h5) begin
            errors++; $display("FAIL b2b_add got done=%b ill=%b res=%h want 1 0 00000005", done_o, illegal_o, result_o);
        end
        @(negedge clk_i);
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("FAIL b2b_single got done=%b want 0", done_o); end
    endtask

    task automatic test_reset_mid_shift();
        int dones = 0;
        issue(kSAIL_ALUCTL_6to0_SLL, 3'd0, 1'b0, 32'h1, 32'd20);
        for (int i = 1; i < 3; i++) begin
            if (done_o) dones++;
            @(negedge clk_i);
        end
        reset_n_i = 1'b0;
        #1;
        checks++;
        if ({done_o, branch_taken_o, illegal_o, result_o, ready_o} !== 36'd0) begin
            errors++; $display("FAIL midreset_out got done=%b br=%b ill=%b res=%h rdy=%b want 0", done_o, branch_taken_o, illegal_o, result_o, ready_o);
        end
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if (ready_o !== 1'b1) begin errors++; $display("FAIL midreset_ready got %b want 1", ready_o); end
        for (int i = 0; i < 25; i++) begin
            if (done_o) dones++;
            @(negedge clk_i);
        end
        checks++;
        if (dones !== 0 || result_o !== 32'h0) begin
            errors++; $display("FAIL midreset_nodone got dones=%0d res=%h want 0 0", dones, result_o);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_logic();
        test_slt();
        test_branch();
        test_shift();
        test_back_to_back();
        for (int i = 0; i < 7; i++) @(negedge clk_i);
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
